// File: rtl/mem_write_checker.sv
// Store-stream self-check: classifies processor stores into pass/fail/timeout and
// optionally traces accepted stores in a show-ahead FIFO (MEM_WRITE_CHECKER_TRACE_EN).
module mem_write_checker #(
  parameter logic [31:0] PASS_ADDR    = 32'd100,
  parameter logic [31:0] PASS_DATA    = 32'd7,
  parameter logic [31:0] SCRATCH_ADDR = 32'd96,
  parameter int          DEPTH        = 8,
  parameter int          TIMEOUT      = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic        trace_rd,
  output logic        trace_valid,
  output logic [31:0] trace_adr,
  output logic [31:0] trace_data,
  output logic        trace_ovf,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [15:0] store_count
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;
  localparam logic [1:0] ST_TMO  = 2'd3;

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   count_q, count_d;
  logic          accept;

  assign accept = (state_q == ST_RUN) && MemWrite;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    if (state_q == ST_RUN) begin
      // A store verdict outranks a timeout landing on the same edge.
      if (MemWrite) begin
        if (DataAdr == PASS_ADDR && WriteData == PASS_DATA)
          state_d = ST_PASS;
        else if (DataAdr != SCRATCH_ADDR)
          state_d = ST_FAIL;
      end else if (cnt_q == CNT_LAST) begin
        state_d = ST_TMO;
      end
      if (cnt_q != CNT_LAST)
        cnt_d = cnt_q + 1'b1;
    end
    if (accept && count_q != 16'hFFFF)
      count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  assign done        = (state_q != ST_RUN);
  assign pass        = (state_q == ST_PASS);
  assign fail        = (state_q == ST_FAIL) || (state_q == ST_TMO);
  assign timeout     = (state_q == ST_TMO);
  assign store_count = count_q;

`ifdef MEM_WRITE_CHECKER_TRACE_EN
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         ovf_q, ovf_d;
  logic [63:0]  mem_q [DEPTH];
  logic [63:0]  head;
  logic         empty, full, push, pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = trace_rd && !empty;
  assign push  = accept && (!full || pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    if (accept && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push)
      mem_q[wr_q[AW-1:0]] <= {DataAdr, WriteData};
  end

  // Show-ahead head, forced to zero while empty so reset values hold.
  assign head        = mem_q[rd_q[AW-1:0]];
  assign trace_valid = !empty;
  assign trace_adr   = empty ? 32'd0 : head[63:32];
  assign trace_data  = empty ? 32'd0 : head[31:0];
  assign trace_ovf   = ovf_q;
`else
  logic trace_unused;
  assign trace_unused = trace_rd | (DEPTH == 0);
  assign trace_valid  = 1'b0;
  assign trace_adr    = 32'd0;
  assign trace_data   = 32'd0;
  assign trace_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker (DEPTH=4, TIMEOUT=20); FIFO checks follow
// MEM_WRITE_CHECKER_TRACE_EN.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        trace_rd = 1'b0;
  logic        trace_valid, trace_ovf, done, pass, fail, timeout;
  logic [31:0] trace_adr, trace_data;
  logic [15:0] store_count;

  int checks = 0;
  int errors = 0;

  mem_write_checker #(.DEPTH(4), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .trace_rd(trace_rd), .trace_valid(trace_valid),
    .trace_adr(trace_adr), .trace_data(trace_data), .trace_ovf(trace_ovf),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .store_count(store_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; MemWrite = 1'b0; trace_rd = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic rd);
    MemWrite = 1'b1; DataAdr = a; WriteData = d; trace_rd = rd;
    tick();
    MemWrite = 1'b0; trace_rd = 1'b0;
    $display("store adr=%0d data=%0d rd=%0b -> done=%0b pass=%0b fail=%0b tmo=%0b cnt=%0d tv=%0b",
             a, d, rd, done, pass, fail, timeout, store_count, trace_valid);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({done, pass, fail, timeout} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags got %b exp 0000", {done, pass, fail, timeout}); end
    checks++; if (store_count !== 16'd0) begin errors++;
      $display("FAIL reset_count got %0d exp 0", store_count); end
    checks++; if ({trace_valid, trace_ovf, trace_adr, trace_data} !== 66'd0) begin errors++;
      $display("FAIL reset_trace got v=%0b o=%0b a=%0h d=%0h exp zeros",
               trace_valid, trace_ovf, trace_adr, trace_data); end
  endtask

  task automatic test_pass();
    do_reset();
    store(32'd96, 32'd0, 1'b1);  // pop on empty is ignored, push lands
    checks++; if ({done, store_count} !== {1'b0, 16'd1}) begin errors++;
      $display("FAIL pass_scratch got done=%0b cnt=%0d exp 0/1", done, store_count); end
    store(32'd100, 32'd7, 1'b0);
    checks++; if ({done, pass, fail, timeout} !== 4'b1100) begin errors++;
      $display("FAIL pass_verdict got %b exp 1100", {done, pass, fail, timeout}); end
    checks++; if (store_count !== 16'd2) begin errors++;
      $display("FAIL pass_count got %0d exp 2", store_count); end
`ifdef MEM_WRITE_CHECKER_TRACE_EN
    checks++; if ({trace_valid, trace_adr, trace_data} !== {1'b1, 32'd96, 32'd0}) begin errors++;
      $display("FAIL pass_head0 got v=%0b a=%0d d=%0d exp 1/96/0", trace_valid, trace_adr, trace_data); end
    trace_rd = 1'b1; tick(); trace_rd = 1'b0;
    checks++; if ({trace_valid, trace_adr, trace_data} !== {1'b1, 32'd100, 32'd7}) begin errors++;
      $display("FAIL pass_head1 got v=%0b a=%0d d=%0d exp 1/100/7", trace_valid, trace_adr, trace_data); end
    trace_rd = 1'b1; tick(); trace_rd = 1'b0;
    checks++; if (trace_valid !== 1'b0) begin errors++;
      $display("FAIL pass_drain got %0b exp 0", trace_valid); end
`else
    checks++; if ({trace_valid, trace_ovf, trace_adr, trace_data} !== 66'd0) begin errors++;
      $display("FAIL pass_notrace got v=%0b o=%0b exp 0", trace_valid, trace_ovf); end
`endif
  endtask

  task automatic test_fail();
    do_reset();
    store(32'd100, 32'd8, 1'b0);
    checks++; if ({done, pass, fail, timeout} !== 4'b1010) begin errors++;
      $display("FAIL fail_verdict got %b exp 1010", {done, pass, fail, timeout}); end
    checks++; if (store_count !== 16'd1) begin errors++;
      $display("FAIL fail_count got %0d exp 1", store_count); end
    store(32'd100, 32'd7, 1'b0);
    checks++; if ({done, pass, fail, timeout, store_count} !== {4'b1010, 16'd1}) begin errors++;
      $display("FAIL fail_terminal got %b cnt=%0d exp 1010 cnt=1", {done, pass, fail, timeout}, store_count); end
`ifdef MEM_WRITE_CHECKER_TRACE_EN
    checks++; if ({trace_valid, trace_adr, trace_data} !== {1'b1, 32'd100, 32'd8}) begin errors++;
      $display("FAIL fail_head got v=%0b a=%0d d=%0d exp 1/100/8", trace_valid, trace_adr, trace_data); end
    trace_rd = 1'b1; tick(); trace_rd = 1'b0;
    checks++; if (trace_valid !== 1'b0) begin errors++;
      $display("FAIL fail_nopush got %0b exp 0", trace_valid); end
`endif
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (19) tick();
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL tmo_early got done=%0b exp 0", done); end
    tick();
    $display("idle 20 cycles -> done=%0b fail=%0b tmo=%0b", done, fail, timeout);
    checks++; if ({done, pass, fail, timeout} !== 4'b1011) begin errors++;
      $display("FAIL tmo_verdict got %b exp 1011", {done, pass, fail, timeout}); end
    do_reset();
    repeat (19) tick();
    store(32'd100, 32'd7, 1'b0);
    checks++; if ({done, pass, fail, timeout} !== 4'b1100) begin errors++;
      $display("FAIL tmo_store_wins got %b exp 1100", {done, pass, fail, timeout}); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) store(32'd96, 32'(i + 1), 1'b0);
    checks++; if ({done, store_count} !== {1'b0, 16'd6}) begin errors++;
      $display("FAIL ovf_count got done=%0b cnt=%0d exp 0/6", done, store_count); end
`ifdef MEM_WRITE_CHECKER_TRACE_EN
    checks++; if ({trace_ovf, trace_valid, trace_data} !== {2'b11, 32'd1}) begin errors++;
      $display("FAIL ovf_flag got o=%0b v=%0b d=%0d exp 1/1/1", trace_ovf, trace_valid, trace_data); end
    store(32'd96, 32'd50, 1'b1);
    checks++; if (store_count !== 16'd7) begin errors++;
      $display("FAIL ovf_count7 got %0d exp 7", store_count); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_d;
      exp_d = (i < 3) ? 32'(i + 2) : 32'd50;
      checks++; if ({trace_valid, trace_data} !== {1'b1, exp_d}) begin errors++;
        $display("FAIL ovf_read%0d got v=%0b d=%0d exp 1/%0d", i, trace_valid, trace_data, exp_d); end
      trace_rd = 1'b1; tick(); trace_rd = 1'b0;
    end
    checks++; if (trace_valid !== 1'b0) begin errors++;
      $display("FAIL ovf_drain got %0b exp 0", trace_valid); end
`else
    checks++; if ({trace_ovf, trace_valid} !== 2'b00) begin errors++;
      $display("FAIL ovf_notrace got o=%0b v=%0b exp 0/0", trace_ovf, trace_valid); end
`endif
  endtask

  task automatic test_midrun_reset();
    do_reset();
    for (int i = 0; i < 3; i++) store(32'd96, 32'd9, 1'b0);
    reset = 1'b0; MemWrite = 1'b1; DataAdr = 32'd100; WriteData = 32'd7;
    tick();
    $display("mid-run reset with store -> done=%0b cnt=%0d tv=%0b", done, store_count, trace_valid);
    checks++; if ({done, pass, fail, timeout, store_count} !== 20'd0) begin errors++;
      $display("FAIL mid_reset got %b cnt=%0d exp 0000 cnt=0", {done, pass, fail, timeout}, store_count); end
    checks++; if ({trace_valid, trace_ovf, trace_adr, trace_data} !== 66'd0) begin errors++;
      $display("FAIL mid_reset_trace got v=%0b o=%0b exp zeros", trace_valid, trace_ovf); end
    reset = 1'b1; MemWrite = 1'b0;
    tick();
    checks++; if ({done, store_count, trace_valid} !== 18'd0) begin errors++;
      $display("FAIL mid_reset_after got done=%0b cnt=%0d v=%0b exp 0", done, store_count, trace_valid); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_overflow();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable self-check stage sitting directly downstream of the single-cycle processor `top`. It consumes the processor's data-memory write port (`MemWrite`, `DataAdr`, `WriteData`) and classifies the store stream into a pass/fail/timeout verdict. It also buffers accepted stores in a small trace FIFO for readout by a debug host or bench. The block replaces ad-hoc negedge checking with a registered, cycle-accurate verdict usable on FPGA as well as in simulation.

## Interface
- `PASS_ADDR`, 100, store address that ends the program successfully when paired with `PASS_DATA`
- `PASS_DATA`, 7, required write data at `PASS_ADDR`
- `SCRATCH_ADDR`, 96, only address a store may target without triggering a verdict
- `DEPTH`, 8, trace FIFO entries; power of two, minimum 2
- `TIMEOUT`, 1000, cycles after reset release with no verdict before timeout; minimum 2

- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset; `reset`=0 at a rising edge resets the block
- `MemWrite`  in  1  processor store strobe, valid for the whole cycle
- `DataAdr`  in  32  store byte address
- `WriteData`  in  32  store data
- `trace_rd`  in  1  pop request for the trace FIFO
- `trace_valid`  out  1  FIFO non-empty; head entry presented on `trace_adr`/`trace_data`
- `trace_adr`  out  32  head entry address
- `trace_data`  out  32  head entry data
- `trace_ovf`  out  1  sticky flag: a store was dropped because the FIFO was full
- `done`  out  1  verdict reached; sticky until reset
- `pass`  out  1  verdict is pass
- `fail`  out  1  verdict is fail (bad store or timeout)
- `timeout`  out  1  verdict came from timeout
- `store_count`  out  16  accepted stores since reset, saturating at 16'hFFFF

## Operation
- FSM states: RUN, PASS, FAIL, TMO. Reset enters RUN.
- RUN, `MemWrite`=1 at an edge: the store is accepted.
  - `DataAdr`==`PASS_ADDR` and `WriteData`==`PASS_DATA` → PASS.
  - Otherwise, `DataAdr`!=`SCRATCH_ADDR` → FAIL. This includes `PASS_ADDR` with wrong data.
  - Otherwise, stay in RUN.
- RUN, no store, and the cycle counter reaches `TIMEOUT`-1 → TMO.
- On the same edge, a store verdict takes priority over timeout.
- PASS, FAIL and TMO are terminal until reset. Stores arriving in a terminal state are ignored: no count, no push, no verdict change.
- Outputs decode from state:
  - PASS → `done`=1, `pass`=1.
  - FAIL → `done`=1, `fail`=1.
  - TMO → `done`=1, `fail`=1, `timeout`=1.
- Each accepted store, including the verdict-causing one, increments `store_count` (saturating) and pushes {`DataAdr`, `WriteData`} into the trace FIFO.
- FIFO behaviour:
  - Show-ahead: the head entry is valid whenever `trace_valid`=1.
  - `trace_rd` with `trace_valid`=1 pops one entry. `trace_rd` when empty is ignored.
  - Push while full and not popping: the store is dropped and `trace_ovf` is set. The store is still counted and still judged.
  - Push and pop on the same edge while full: both happen, no drop.
  - Push and pop on the same edge while empty: the push occurs and the pop is ignored.
  - Pointers are log2(`DEPTH`)+1 bits; the extra MSB distinguishes full from empty.
- Trace readout continues in terminal states.

## Timing
- Reset values: `done`, `pass`, `fail`, `timeout`, `trace_valid`, `trace_ovf` = 0; `store_count`=0; `trace_adr`, `trace_data` = 0; FIFO empty; cycle counter = 0.
- Verdict latency: a store sampled at edge N drives `done`/`pass`/`fail` high after edge N, i.e. in cycle N+1.
- Timeout: `timeout` asserts in the cycle after the edge where the counter equals `TIMEOUT`-1. The counter starts at the first edge with `reset`=1.
- FIFO latency: a store pushed at edge N into an empty FIFO gives `trace_valid`=1 in cycle N+1.
- A pop at edge N presents the next head, or deasserts `trace_valid`, in cycle N+1.
- `store_count` updates the cycle after the accepting edge.
- Reset asserted mid-run clears all state at that edge, regardless of `MemWrite`. A store on that edge is discarded.

## Configuration
- `MEM_WRITE_CHECKER_TRACE_EN` defined: the trace FIFO and `trace_ovf` logic are compiled in as described above.
- Macro undefined:
  - No FIFO storage is instantiated.
  - `trace_valid`, `trace_ovf`, `trace_adr` and `trace_data` are tied to 0.
  - `trace_rd` is ignored.
  - Verdict logic and `store_count` are unchanged.

## Test plan
- Store (96,0) then (100,7) → `pass`=1 and `done`=1 one cycle after the second store; `fail`=0; `store_count`=2; FIFO holds (96,0),(100,7) in order.
- Store (100,8) → `fail`=1, `pass`=0, `timeout`=0, `store_count`=1. A subsequent store (100,7) leaves the verdict and count unchanged.
- No stores with `TIMEOUT`=20 → `done`=`fail`=`timeout`=1 exactly 20 cycles after reset release. A store (100,7) on the edge where the counter is at 19 → `pass` instead.
- `DEPTH`=4, six stores to 96 with no reads → four entries retained (first four), `trace_ovf`=1, `store_count`=6. A store while full with `trace_rd`=1 → no drop.
- Mid-run reset: after three stores to 96, drive `reset`=0 for one edge with `MemWrite`=1 → all outputs return to reset values and the FIFO is empty.
- With macro undefined: the pass sequence still yields `pass`=1; `trace_valid` stays 0 throughout.
